// File: rtl/es9821q_cfg_pkg.sv
// Shared types and configuration ROM for the ES9821Q I2C configuration engine.
package es9821q_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK1,
    ST_REG,
    ST_ACK2,
    ST_DATA,
    ST_ACK3,
    ST_STOP,
    ST_GAP
  } state_e;

  localparam logic [6:0]   DEV_ADDR_DEFAULT = 7'h10;
  localparam int unsigned  ROM_LEN          = 4;
  localparam int unsigned  ROM_IDX_W        = $clog2(ROM_LEN);

  // {register, data} words; element 0 is written first.
  localparam logic [ROM_LEN-1:0][15:0] CFG_ROM = {
    16'h0300,
    16'h0204,
    16'h0100,
    16'h0055
  };

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick divider: one-cycle tick every DIV clocks while enabled.
module i2c_tick_gen #(
  parameter int unsigned DIV = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: held at zero while disabled, wraps at DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DIV - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_c = en && (cnt_q == CNT_W'(DIV - 1));

endmodule

// File: rtl/i2c_adc_controller.sv
// Single-master I2C write engine that streams the ES9821Q configuration ROM.
module i2c_adc_controller
  import es9821q_cfg_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned I2C_FREQ = 100_000,
  parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int unsigned NUM_REGS = ROM_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic scl,
  inout  wire  sda,
  output logic busy,
  output logic ack_error
);

  localparam int unsigned DIV = CLK_FREQ / (4 * I2C_FREQ);

  state_e               state_q, state_d;
  logic [1:0]           qtr_q, qtr_d;
  logic [2:0]           bit_q, bit_d;
  logic [ROM_IDX_W-1:0] idx_q, idx_d;
  logic                 scl_q, scl_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 busy_q, busy_d;
  logic                 ack_error_q, ack_error_d;
  logic                 nack_q, nack_d;
  logic                 tick_c;
  logic [15:0]          rom_word;
  logic [7:0]           tx_byte;

  i2c_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (busy_q),
    .tick_c (tick_c)
  );

  // Byte currently being shifted out.
  always_comb begin
    rom_word = CFG_ROM[idx_q];
    tx_byte  = {DEV_ADDR, 1'b0};
    if (state_q == ST_REG) begin
      tx_byte = rom_word[15:8];
    end else if (state_q == ST_DATA) begin
      tx_byte = rom_word[7:0];
    end
  end

  // Next-state and bus control; every action happens on a quarter tick.
  always_comb begin
    state_d     = state_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    idx_d       = idx_q;
    scl_d       = scl_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    ack_error_d = ack_error_q;
    nack_d      = nack_q;

    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d     = ST_START;
        qtr_d       = 2'd0;
        idx_d       = '0;
        busy_d      = 1'b1;
        ack_error_d = 1'b0;
        nack_d      = 1'b0;
        scl_d       = 1'b1;
        sda_oe_d    = 1'b0;
      end
    end else if (tick_c) begin
      qtr_d = qtr_q + 2'd1;
      unique case (state_q)
        ST_START: begin
          if (qtr_q == 2'd0) sda_oe_d = 1'b1;
          if (qtr_q == 2'd1) scl_d = 1'b0;
          if (qtr_q == 2'd3) begin
            state_d = ST_ADDR;
            bit_d   = 3'd7;
          end
        end
        ST_ADDR, ST_REG, ST_DATA: begin
          if (qtr_q == 2'd0) sda_oe_d = ~tx_byte[bit_q];
          if (qtr_q == 2'd1) scl_d = 1'b1;
          if (qtr_q == 2'd3) begin
            scl_d = 1'b0;
            if (bit_q == 3'd0) begin
              state_d = (state_q == ST_ADDR) ? ST_ACK1 :
                        (state_q == ST_REG)  ? ST_ACK2 : ST_ACK3;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
        end
        ST_ACK1, ST_ACK2, ST_ACK3: begin
          if (qtr_q == 2'd0) sda_oe_d = 1'b0;
          if (qtr_q == 2'd1) scl_d = 1'b1;
          if (qtr_q == 2'd2) begin
            // Only a clean 0 is an ACK; 1, z or x fall through as NACK.
            nack_d = 1'b1;
            if (sda == 1'b0) nack_d = 1'b0;
          end
          if (qtr_q == 2'd3) begin
            scl_d = 1'b0;
            bit_d = 3'd7;
            if (nack_q) begin
              ack_error_d = 1'b1;
              state_d     = ST_STOP;
            end else begin
              state_d = (state_q == ST_ACK1) ? ST_REG :
                        (state_q == ST_ACK2) ? ST_DATA : ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (qtr_q == 2'd0) begin
            scl_d    = 1'b0;
            sda_oe_d = 1'b1;
          end
          if (qtr_q == 2'd1) scl_d = 1'b1;
          if (qtr_q == 2'd2) sda_oe_d = 1'b0;
          if (qtr_q == 2'd3) begin
            if (nack_q) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (qtr_q == 2'd3) begin
            if (idx_q == ROM_IDX_W'(NUM_REGS - 1)) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              idx_d   = idx_q + ROM_IDX_W'(1);
              state_d = ST_START;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and registered bus outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      qtr_q       <= 2'd0;
      bit_q       <= 3'd7;
      idx_q       <= '0;
      scl_q       <= 1'b1;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      ack_error_q <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      idx_q       <= idx_d;
      scl_q       <= scl_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      ack_error_q <= ack_error_d;
      nack_q      <= nack_d;
    end
  end

  assign scl       = scl_q;
  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign busy      = busy_q;
  assign ack_error = ack_error_q;

endmodule

// File: tb/tb_i2c_adc_controller.sv
// Directed bench: I2C bus decoder plus ACKing slave model around the controller.
module tb_i2c_adc_controller;

  localparam int unsigned CLK_FREQ = 4_000_000;
  localparam int unsigned I2C_FREQ = 100_000;
  localparam int unsigned DIV      = CLK_FREQ / (4 * I2C_FREQ);  // 10 clocks per quarter
  localparam int unsigned BIT_CYC  = 4 * DIV;                    // 40 clocks per bit
  localparam logic [23:0] EXP_TX [4] = '{24'h200055, 24'h200100, 24'h200204, 24'h200300};

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic scl;
  logic busy;
  logic ack_error;
  tri   sda;

  logic ack_en;
  logic slave_ack;

  pullup (sda);
  assign sda = slave_ack ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_adc_controller #(
    .CLK_FREQ (CLK_FREQ),
    .I2C_FREQ (I2C_FREQ),
    .DEV_ADDR (7'h10),
    .NUM_REGS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .scl       (scl),
    .sda       (sda),
    .busy      (busy),
    .ack_error (ack_error)
  );

  int vectors = 0;
  int miscompares = 0;

  // Bus monitor state.
  int          cyc = 0;
  logic        s, d;
  logic        prev_s = 1'b1;
  logic        prev_d = 1'b1;
  logic        in_tx = 1'b0;
  int          bitcnt = 0;
  int          byte_cnt = 0;
  logic [7:0]  shreg = '0;
  logic [23:0] cur_tx = '0;
  logic [23:0] tx_q[$];
  int          starts = 0;
  int          proto_err = 0;
  int          last_fall = 0;
  int          last_rise = 0;
  int          lo_min = 1_000_000, lo_max = 0;
  int          hi_min = 1_000_000, hi_max = 0;

  initial slave_ack = 1'b0;

  // Decode START/STOP/bits, ACK each byte, and time SCL phases inside bytes.
  always @(negedge clk) begin
    cyc++;
    s = scl;
    d = (sda === 1'b0) ? 1'b0 : 1'b1;
    if (!reset) begin
      in_tx     = 1'b0;
      bitcnt    = 0;
      byte_cnt  = 0;
      slave_ack = 1'b0;
    end else if (prev_s && s && prev_d && !d) begin
      if (in_tx) proto_err++;
      in_tx    = 1'b1;
      starts++;
      bitcnt   = 0;
      byte_cnt = 0;
      cur_tx   = '0;
    end else if (prev_s && s && !prev_d && d) begin
      if (in_tx && bitcnt > 1) proto_err++;
      if (in_tx && byte_cnt == 3) tx_q.push_back(cur_tx);
      in_tx  = 1'b0;
      bitcnt = 0;
    end else if (!prev_s && s && in_tx) begin
      if (bitcnt >= 1 && bitcnt <= 8) begin
        if (cyc - last_fall < lo_min) lo_min = cyc - last_fall;
        if (cyc - last_fall > lo_max) lo_max = cyc - last_fall;
      end
      if (bitcnt < 8) shreg = {shreg[6:0], d};
      bitcnt++;
      last_rise = cyc;
    end else if (prev_s && !s && in_tx) begin
      if (bitcnt >= 1) begin
        if (cyc - last_rise < hi_min) hi_min = cyc - last_rise;
        if (cyc - last_rise > hi_max) hi_max = cyc - last_rise;
      end
      last_fall = cyc;
      if (bitcnt == 8) begin
        cur_tx    = {cur_tx[15:0], shreg};
        slave_ack = ack_en;
      end else if (bitcnt == 9) begin
        slave_ack = 1'b0;
        bitcnt    = 0;
        byte_cnt++;
      end
    end
    prev_s = s;
    prev_d = d;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_monitor();
    tx_q.delete();
    starts    = 0;
    proto_err = 0;
    lo_min    = 1_000_000;
    lo_max    = 0;
    hi_min    = 1_000_000;
    hi_max    = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // One complete ACKed sequence; optionally hammer start while busy.
  task automatic run_full(input string tag, input bit spam);
    int cnt;
    logic [31:0] obs;
    clear_monitor();
    pulse_start();
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    check({tag, "_ackerr_clr"}, 32'(ack_error), 32'd0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 8000) begin
      @(negedge clk);
      cnt++;
      if (spam) start = ((cnt % 600) == 300);
    end
    start = 1'b0;
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_duration"}, 32'(cnt >= 4 * 29 * BIT_CYC && cnt <= 4 * 32 * BIT_CYC), 32'd1);
    repeat (100) @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_starts"}, 32'(starts), 32'd4);
    check({tag, "_tx_count"}, 32'(tx_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      obs = (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hDEAD_BEEF;
      check($sformatf("%s_tx%0d", tag, i), obs, 32'(EXP_TX[i]));
    end
    check({tag, "_ackerr"}, 32'(ack_error), 32'd0);
    check({tag, "_sda_hold"}, 32'(proto_err), 32'd0);
    check({tag, "_scl_lo_min"}, 32'(lo_min), 32'(2 * DIV));
    check({tag, "_scl_lo_max"}, 32'(lo_max), 32'(2 * DIV));
    check({tag, "_scl_hi_min"}, 32'(hi_min), 32'(2 * DIV));
    check({tag, "_scl_hi_max"}, 32'(hi_max), 32'(2 * DIV));
    check({tag, "_scl_idle"}, 32'(scl), 32'd1);
    check({tag, "_sda_idle"}, 32'(sda === 1'b1), 32'd1);
  endtask

  initial begin
    int cnt;
    reset  = 1'b0;
    start  = 1'b0;
    ack_en = 1'b1;

    // Reset then idle.
    #20 reset = 1'b1;
    @(negedge clk);
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda === 1'b1), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ackerr", 32'(ack_error), 32'd0);
    repeat (50) @(negedge clk);
    check("idle_scl", 32'(scl), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_starts", 32'(starts), 32'd0);

    // Full sequence with an ACKing slave.
    run_full("full", 1'b0);

    // Start pulses while busy must be ignored.
    run_full("spam", 1'b1);

    // No slave: first ACK samples a released line.
    ack_en = 1'b0;
    clear_monitor();
    pulse_start();
    check("nack_busy_rise", 32'(busy), 32'd1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("nack_busy_fall", 32'(busy), 32'd0);
    check("nack_duration", 32'(cnt >= 8 * BIT_CYC && cnt <= 13 * BIT_CYC), 32'd1);
    check("nack_ackerr", 32'(ack_error), 32'd1);
    check("nack_scl", 32'(scl), 32'd1);
    check("nack_sda", 32'(sda === 1'b1), 32'd1);
    check("nack_stop", 32'(in_tx), 32'd0);
    repeat (200) @(negedge clk);
    check("nack_starts", 32'(starts), 32'd1);
    check("nack_tx_count", 32'(tx_q.size()), 32'd0);
    check("nack_sticky", 32'(ack_error), 32'd1);
    check("nack_sda_hold", 32'(proto_err), 32'd0);

    // Accepted start clears the flag; reset lands in the first DATA byte.
    ack_en = 1'b1;
    clear_monitor();
    pulse_start();
    check("mid_ackerr_clr", 32'(ack_error), 32'd0);
    check("mid_busy_rise", 32'(busy), 32'd1);
    cnt = 0;
    while (!(byte_cnt == 2 && bitcnt == 4) && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check("mid_reached_data", 32'(byte_cnt == 2 && bitcnt == 4), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_scl", 32'(scl), 32'd1);
    check("mid_rst_sda", 32'(sda === 1'b1), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ackerr", 32'(ack_error), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Fresh run restarts from entry 0.
    run_full("after_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
